pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Two-entry elastic pipeline register: the consuming end of the enable-gated flip-flop storage used between processor stages. It accepts a word on a valid/ready input handshake and presents it on a valid/ready output handshake. A skid entry absorbs one extra word when the downstream stage stalls, so the upstream ready depends only on registered state. It sits between adjacent pipeline stages (e.g. fetch→decode, decode→execute) and supports a synchronous flush for branch/exception squash.

## Interface
- WIDTH, 16, data word width in bits
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- flush  input  1  synchronous squash; empties both entries
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  upstream word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  oldest stored word
- level  output  2  occupancy: 0, 1 or 2

## Operation
- Storage: main entry (main_valid, main_data) and skid entry (skid_valid, skid_data).
- in_accept = in_valid & in_ready; out_take = out_valid & out_ready.
- in_ready = !skid_valid; out_valid = main_valid; out_data = main_data; level = main_valid + skid_valid. All outputs derive from registers only, with no combinational path from inputs.
- States (encoded by valid bits):
  - EMPTY (0,0):
    - in_accept → ONE, main ← in_data.
  - ONE (1,0):
    - in_accept & out_take → ONE, main ← in_data.
    - in_accept only → FULL, skid ← in_data.
    - out_take only → EMPTY.
    - neither → hold.
  - FULL (1,1): in_ready=0, so no accept.
    - out_take → ONE, main ← skid_data, skid cleared.
    - else hold.
- Ordering strictly FIFO; no word dropped or duplicated except by flush/reset.
- While out_valid=1 and out_ready=0, out_data is held stable.
- flush: next state EMPTY regardless of in_valid/out_ready. A word offered in the flush cycle is discarded even though in_ready may read 1. Downstream must ignore out_take in the flush cycle; the word is squashed either way.
- Priority: reset > flush > normal operation.
- Data registers load only on their own write condition. The valid bits are the only state cleared by flush.

## Timing
- Reset values: out_valid=0, in_ready=1, level=0, out_data=0 (main_data and skid_data cleared to 0).
- Reset mid-operation: the next edge with reset=1 discards all stored words. The following cycle shows EMPTY values.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N (visible in cycle N+1) when the block was EMPTY, or when ONE with a simultaneous take.
- Throughput: one word per cycle sustained when out_ready is held 1.
- Stall: out_ready falls while streaming. At most one further word is accepted (into skid), then in_ready=0 from the next cycle.
- Release from FULL: in_ready returns to 1 in the cycle after the first out_take. The skid word appears on out_data the same cycle.
- Simultaneous flush and in_valid in any state: result EMPTY, no word retained.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, in_data=16'hFFFF → out_valid=0, in_ready=1, level=0, out_data=0 after release.
- Streaming: out_ready=1, send 16'h0001..16'h0008 on consecutive cycles → each appears one cycle later in order. in_ready stays 1, level stays 1 while streaming.
- Stall/skid: stream 16'hA000, 16'hA001, 16'hA002 with out_ready=0 from the cycle after A000 is accepted:
  - A001 is accepted into skid and level=2.
  - in_ready=0 and A002 is held upstream.
  - out_data=A000 stays stable for 3 stalled cycles.
  - Raising out_ready then yields A000, A001, A002 in order.
- Drain to empty: load 16'h1234, then out_ready=1 with in_valid=0 → one take, then out_valid=0 and level=0.
- Flush in FULL: fill with 16'hBEEF, 16'hCAFE, then assert flush with in_valid=1, in_data=16'hDEAD → next cycle level=0, out_valid=0, in_ready=1. No BEEF, CAFE or DEAD emerges afterwards.
- Random: random in_valid/out_ready for 1000 cycles against a scoreboard FIFO → no loss, duplication or reordering; level ≤ 2 always.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic pipeline register with skid entry and flush
module pipe_skid_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);
  // bit0 = main_valid, bit1 = skid_valid
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] main_data, skid_data;
  logic main_valid, skid_valid, in_accept, out_take, main_ld, skid_ld;
  assign main_valid = state[0];
  assign skid_valid = state[1];
  assign in_ready = !skid_valid;
  assign out_valid = main_valid;
  assign out_data = main_data;
  assign level = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
  assign in_accept = in_valid & in_ready;
  assign out_take = out_valid & out_ready;
  always_comb begin
    nxt = state;
    main_ld = !flush & ((in_accept & (!main_valid | out_take)) | (skid_valid & out_take));
    skid_ld = !flush & in_accept & main_valid & !out_take;
    case (state)
      EMPTY: nxt = in_accept ? ONE : EMPTY;
      ONE:   nxt = in_accept ? (out_take ? ONE : FULL) : (out_take ? EMPTY : ONE);
      FULL:  nxt = out_take ? ONE : FULL;
      default: nxt = EMPTY;
    endcase
    if (flush) nxt = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state <= nxt;
      if (main_ld) main_data <= skid_valid ? skid_data : in_data;
      if (skid_ld) skid_data <= in_data;
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random scoreboard checks for pipe_skid_reg
module tb_pipe_skid_reg;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] in_data = '0, out_data;
  logic [1:0] level;
  logic [15:0] q[$];
  int n_checks = 0, n_fail = 0;

  pipe_skid_reg #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("level", 32'(level), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  task automatic cyc(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(negedge clk);
    check_state();
    if (fl) q.delete();
    else begin
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(in_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; in_valid = 1; in_data = 16'hFFFF; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0; in_valid = 0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 16'hA000, 1'b1, 1'b0);
    cyc(1'b1, 16'hA001, 1'b0, 1'b0);
    chk("stall_level", 32'(level), 32'h2);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      chk("stall_hold", 32'(out_data), 32'hA000);
      cyc(1'b1, 16'hA002, 1'b0, 1'b0);
    end
    cyc(1'b1, 16'hA002, 1'b1, 1'b0);
    chk("release_in_ready", 32'(in_ready), 32'h1);
    chk("release_skid_word", 32'(out_data), 32'hA001);
    cyc(1'b1, 16'hA002, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("drain_word", 32'(out_data), 32'h1234);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drain_out_valid", 32'(out_valid), 32'h0);
    chk("drain_level", 32'(level), 32'h0);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    cyc(1'b1, 16'hCAFE, 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'h2);
    cyc(1'b1, 16'hDEAD, 1'b1, 1'b1);
    chk("flush_level", 32'(level), 32'h0);
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    repeat (3) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 16'h5555, 1'b0, 1'b0);
    cyc(1'b1, 16'h6666, 1'b0, 1'b0);
    reset = 1;
    @(posedge clk); #1 reset = 0; in_valid = 0;
    q.delete();
    chk("midrst_level", 32'(level), 32'h0);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 1000; i++) begin
      cyc(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(49) == 0));
      chk("level_max", 32'(level <= 2'd2), 32'h1);
    end
    repeat (3) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("final_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
